// File: rtl/fetch_queue_pkg.sv
// Shared defaults and sizing helpers for the fetch queue slice.
package fetch_queue_pkg;

    localparam int unsigned FQ_ADDR_W   = 32;
    localparam int unsigned FQ_INST_W   = 32;
    localparam int unsigned FQ_DEPTH    = 4;
    localparam int unsigned FQ_RESET_PC = 0;

    // Pointers carry one extra wrap bit so full and empty differ.
    function automatic int unsigned fq_ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned fq_entry_w(input int unsigned addr_w, input int unsigned inst_w);
        return addr_w + inst_w + 1;
    endfunction

endpackage

// File: rtl/fetch_buf_mem.sv
// DEPTH-entry {pc, inst, filled} register array: allocate port, fill port, async head read.
module fetch_buf_mem
    import fetch_queue_pkg::*;
#(
    parameter  int unsigned ADDR_W = FQ_ADDR_W,
    parameter  int unsigned INST_W = FQ_INST_W,
    parameter  int unsigned DEPTH  = FQ_DEPTH,
    localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_we_i,
    input  logic [IDX_W-1:0]  alloc_idx_i,
    input  logic [ADDR_W-1:0] alloc_pc_i,
    input  logic              fill_we_i,
    input  logic [IDX_W-1:0]  fill_idx_i,
    input  logic [INST_W-1:0] fill_inst_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [ADDR_W-1:0] rd_pc_o,
    output logic [INST_W-1:0] rd_inst_o,
    output logic              rd_filled_o
);

    logic [ADDR_W-1:0] pc_q     [DEPTH];
    logic [INST_W-1:0] inst_q   [DEPTH];
    logic [DEPTH-1:0]  filled_q;

    // Allocate and fill never target the same slot: allocation only lands on a free entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
            filled_q <= '0;
        end else begin
            if (alloc_we_i) begin
                pc_q[alloc_idx_i]     <= alloc_pc_i;
                filled_q[alloc_idx_i] <= 1'b0;
            end
            if (fill_we_i) begin
                inst_q[fill_idx_i]   <= fill_inst_i;
                filled_q[fill_idx_i] <= 1'b1;
            end
        end
    end

    assign rd_pc_o     = pc_q[rd_idx_i];
    assign rd_inst_o   = inst_q[rd_idx_i];
    assign rd_filled_o = filled_q[rd_idx_i];

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: issues pipelined ROM requests, buffers responses in order, flushes on redirect.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter  int unsigned       ADDR_W   = FQ_ADDR_W,
    parameter  int unsigned       INST_W   = FQ_INST_W,
    parameter  int unsigned       DEPTH    = FQ_DEPTH,
    parameter  logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FQ_RESET_PC),
    parameter  int unsigned       PC_STEP  = 4,
    localparam int unsigned       PTR_W    = fq_ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic              rom_gnt_i,
    input  logic              rom_rvalid_i,
    input  logic [INST_W-1:0] rom_data_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              id_valid_o,
    input  logic              id_ready_i,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic [PTR_W-1:0]  occ_o
);

    localparam int unsigned       IDX_W      = PTR_W - 1;
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(PC_STEP - 1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  alloc_ptr_q, alloc_ptr_d;
    logic [PTR_W-1:0]  fill_ptr_q, fill_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic [ADDR_W-1:0] last_pc_q, last_pc_d;
    logic [INST_W-1:0] last_inst_q, last_inst_d;

    logic [PTR_W-1:0]  occ;
    logic [PTR_W-1:0]  unfilled;
    logic [PTR_W:0]    inflight;
    logic              grant;
    logic              drop_hit;
    logic              fill_en;
    logic              head_valid;
    logic              consume;
    logic              rv_counted;
    logic [ADDR_W-1:0] head_pc;
    logic [INST_W-1:0] head_inst;
    logic              head_filled;

    assign occ      = alloc_ptr_q - rd_ptr_q;
    assign unfilled = alloc_ptr_q - fill_ptr_q;
    assign inflight = {1'b0, occ} + {1'b0, drop_cnt_q};

    // Responses still owed to flushed requests occupy issue slots until they drain.
    assign rom_ce_o   = rst && !redirect_i && (inflight < (PTR_W+1)'(DEPTH));
    assign rom_addr_o = pc_q;
    assign grant      = rom_ce_o && rom_gnt_i;
    assign drop_hit   = rom_rvalid_i && (drop_cnt_q != '0);
    assign fill_en    = rom_rvalid_i && !drop_hit && (fill_ptr_q != alloc_ptr_q);
    assign rv_counted = rom_rvalid_i && ((drop_cnt_q != '0) || (unfilled != '0));

    assign head_valid = (rd_ptr_q != fill_ptr_q) && head_filled;
    assign consume    = head_valid && id_ready_i;
    assign id_valid_o = head_valid;
    assign id_pc_o    = head_valid ? head_pc : last_pc_q;
    assign id_inst_o  = head_valid ? head_inst : last_inst_q;
    assign occ_o      = occ;

    always_comb begin
        pc_d        = pc_q;
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        drop_cnt_d  = drop_cnt_q;
        last_pc_d   = last_pc_q;
        last_inst_d = last_inst_q;
        if (grant) begin
            alloc_ptr_d = alloc_ptr_q + 1'b1;
            pc_d        = pc_q + STEP;
        end
        if (fill_en)  fill_ptr_d = fill_ptr_q + 1'b1;
        if (drop_hit) drop_cnt_d = drop_cnt_q - 1'b1;
        if (consume)  rd_ptr_d   = rd_ptr_q + 1'b1;
        if (head_valid) begin
            last_pc_d   = head_pc;
            last_inst_d = head_inst;
        end
        // A response arriving with the redirect is charged against the new drop count.
        if (redirect_i) begin
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            rd_ptr_d    = '0;
            pc_d        = redirect_pc_i & ALIGN_MASK;
            drop_cnt_d  = drop_cnt_q + unfilled - PTR_W'(rv_counted);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= RESET_PC;
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            rd_ptr_q    <= '0;
            drop_cnt_q  <= '0;
            last_pc_q   <= '0;
            last_inst_q <= '0;
        end else begin
            pc_q        <= pc_d;
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            drop_cnt_q  <= drop_cnt_d;
            last_pc_q   <= last_pc_d;
            last_inst_q <= last_inst_d;
        end
    end

    fetch_buf_mem #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk         (clk),
        .rst_n       (rst),
        .alloc_we_i  (grant),
        .alloc_idx_i (alloc_ptr_q[IDX_W-1:0]),
        .alloc_pc_i  (pc_q),
        .fill_we_i   (fill_en && !redirect_i),
        .fill_idx_i  (fill_ptr_q[IDX_W-1:0]),
        .fill_inst_i (rom_data_i),
        .rd_idx_i    (rd_ptr_q[IDX_W-1:0]),
        .rd_pc_o     (head_pc),
        .rd_inst_o   (head_inst),
        .rd_filled_o (head_filled)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: ROM model with variable latency and an in-order ID scoreboard.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic        rom_gnt;
    logic        rom_rvalid;
    logic [31:0] rom_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid_o;
    logic        id_ready;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic [2:0]  occ_o;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } req_t;

    req_t        pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] gnt_log[$];
    int unsigned lat;
    int unsigned edge_cnt;
    int unsigned hs_cnt;
    int unsigned hs_before;
    int unsigned occ_max;
    logic        force_rv;
    logic        rv_last;
    logic        hs_last;
    logic        first_set;
    logic [31:0] first_pc;
    int          n_pass;
    int          n_total;

    fetch_queue #(
        .ADDR_W   (32),
        .INST_W   (32),
        .DEPTH    (4),
        .RESET_PC (32'h0),
        .PC_STEP  (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rom_ce_o      (rom_ce_o),
        .rom_addr_o    (rom_addr_o),
        .rom_gnt_i     (rom_gnt),
        .rom_rvalid_i  (rom_rvalid),
        .rom_data_i    (rom_data),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .id_valid_o    (id_valid_o),
        .id_ready_i    (id_ready),
        .id_pc_o       (id_pc_o),
        .id_inst_o     (id_inst_o),
        .occ_o         (occ_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sb_restart(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(i * 4));
        gnt_log.delete();
        hs_cnt    = 0;
        occ_max   = 0;
        first_set = 1'b0;
        first_pc  = 'x;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        step(8);
        rst = 1'b1;
        sb_restart(32'h0);
    endtask

    // ROM model and ID monitor, evaluated 2 time units before every rising edge.
    initial begin
        logic [31:0] e;
        req_t        r;
        rom_rvalid = 1'b0;
        rom_data   = '0;
        edge_cnt   = 0;
        forever begin
            @(negedge clk);
            #3;
            rv_last = 1'b0;
            hs_last = 1'b0;
            if (force_rv) begin
                rom_rvalid = 1'b1;
                rom_data   = 32'hDEAD_BEEF;
                force_rv   = 1'b0;
            end else if (pend.size() > 0 && pend[0].due <= edge_cnt) begin
                r          = pend.pop_front();
                rom_rvalid = 1'b1;
                rom_data   = ~r.addr;
                rv_last    = 1'b1;
            end else begin
                rom_rvalid = 1'b0;
                rom_data   = '0;
            end
            if (rst && rom_ce_o && rom_gnt) begin
                pend.push_back('{addr: rom_addr_o, due: edge_cnt + lat});
                gnt_log.push_back(rom_addr_o);
            end
            if (rst && id_valid_o && id_ready) begin
                hs_last = 1'b1;
                chk("sb_avail", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("sb_pc", id_pc_o, e);
                    chk("sb_inst", id_inst_o, ~e);
                end
                if (!first_set) begin
                    first_pc  = id_pc_o;
                    first_set = 1'b1;
                end
                hs_cnt++;
            end
            if (32'(occ_o) > occ_max) occ_max = 32'(occ_o);
            edge_cnt++;
        end
    end

    initial begin
        n_pass      = 0;
        n_total     = 0;
        rst         = 1'b1;
        rom_gnt     = 1'b1;
        id_ready    = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        force_rv    = 1'b0;
        lat         = 1;
        sb_restart(32'h0);
        #1 rst = 1'b0;
        #1;
        chk("rst_ce", 32'(rom_ce_o), 32'd0);
        chk("rst_valid", 32'(id_valid_o), 32'd0);
        chk("rst_pc", id_pc_o, 32'h0);
        chk("rst_inst", id_inst_o, 32'h0);
        chk("rst_occ", 32'(occ_o), 32'd0);

        // Streaming, 1-cycle ROM, ID always ready.
        @(negedge clk);
        rst = 1'b1;
        sb_restart(32'h0);
        step(1);
        chk("t1_valid_e1", 32'(id_valid_o), 32'd0);
        chk("t1_occ_e1", 32'(occ_o), 32'd1);
        step(1);
        chk("t1_valid_e2", 32'(id_valid_o), 32'd1);
        chk("t1_pc_e2", id_pc_o, 32'h0);
        step(10);
        chk("t1_addr0", gnt_log[0], 32'h0);
        chk("t1_addr1", gnt_log[1], 32'h4);
        chk("t1_addr2", gnt_log[2], 32'h8);
        chk("t1_occmax", occ_max, 32'd2);
        chk("t1_hs", hs_cnt, 32'd10);

        // ID stalled from reset: buffer fills to DEPTH, then drains in order.
        id_ready = 1'b0;
        do_reset();
        step(10);
        chk("t2_ngnt", 32'(gnt_log.size()), 32'd4);
        chk("t2_addr3", gnt_log[3], 32'hC);
        chk("t2_ce", 32'(rom_ce_o), 32'd0);
        chk("t2_occ", 32'(occ_o), 32'd4);
        chk("t2_valid", 32'(id_valid_o), 32'd1);
        chk("t2_head", id_pc_o, 32'h0);
        id_ready = 1'b1;
        step(10);
        chk("t2_resume", gnt_log[4], 32'h10);
        chk("t2_drained", 32'(hs_cnt >= 5), 32'd1);

        // Spurious response with nothing outstanding.
        rom_gnt = 1'b0;
        do_reset();
        step(2);
        force_rv = 1'b1;
        step(2);
        chk("t5_occ", 32'(occ_o), 32'd0);
        chk("t5_valid", 32'(id_valid_o), 32'd0);
        chk("t5_ce", 32'(rom_ce_o), 32'd1);
        chk("t5_fill", 32'(dut.fill_ptr_q), 32'd0);

        // Redirect with 4 slow requests in flight: all four responses discarded.
        rom_gnt = 1'b1;
        lat     = 6;
        do_reset();
        step(4);
        chk("t3_occ4", 32'(occ_o), 32'd4);
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        #1;
        chk("t3_ce_forced", 32'(rom_ce_o), 32'd0);
        step(1);
        redirect = 1'b0;
        sb_restart(32'h100);
        chk("t3_valid", 32'(id_valid_o), 32'd0);
        chk("t3_occ0", 32'(occ_o), 32'd0);
        chk("t3_drop4", 32'(dut.drop_cnt_q), 32'd4);
        step(2);
        chk("t3_drop3", 32'(dut.drop_cnt_q), 32'd3);
        step(18);
        chk("t3_drop0", 32'(dut.drop_cnt_q), 32'd0);
        chk("t3_addr", gnt_log[0], 32'h100);
        chk("t3_first", first_pc, 32'h100);

        // Redirect coinciding with a response and an ID handshake.
        lat = 2;
        do_reset();
        step(10);
        hs_before   = hs_cnt;
        redirect    = 1'b1;
        redirect_pc = 32'h2000;
        step(1);
        redirect = 1'b0;
        chk("t4_rv_at_edge", 32'(rv_last), 32'd1);
        chk("t4_hs_at_edge", 32'(hs_last), 32'd1);
        chk("t4_hs_done", hs_cnt, hs_before + 1);
        chk("t4_drop1", 32'(dut.drop_cnt_q), 32'd1);
        sb_restart(32'h2000);
        step(10);
        chk("t4_first", first_pc, 32'h2000);
        chk("t4_drop0", 32'(dut.drop_cnt_q), 32'd0);

        // Back-to-back redirects: second target wins.
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        step(1);
        redirect_pc = 32'h407;
        step(1);
        redirect = 1'b0;
        sb_restart(32'h404);
        step(12);
        chk("t4b_addr", gnt_log[0], 32'h404);
        chk("t4b_first", first_pc, 32'h404);
        chk("t4b_drop0", 32'(dut.drop_cnt_q), 32'd0);

        // Asynchronous reset mid-burst with 3 outstanding.
        lat = 6;
        do_reset();
        step(3);
        #1 rst = 1'b0;
        #1;
        chk("t6_ce", 32'(rom_ce_o), 32'd0);
        chk("t6_occ", 32'(occ_o), 32'd0);
        chk("t6_valid", 32'(id_valid_o), 32'd0);
        chk("t6_pc", id_pc_o, 32'h0);
        chk("t6_inst", id_inst_o, 32'h0);
        @(negedge clk);
        rom_gnt = 1'b0;
        rst     = 1'b1;
        sb_restart(32'h0);
        step(8);
        chk("t6_late_occ", 32'(occ_o), 32'd0);
        chk("t6_late_valid", 32'(id_valid_o), 32'd0);
        rom_gnt = 1'b1;
        step(12);
        chk("t6_addr", gnt_log[0], 32'h0);
        chk("t6_first", first_pc, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
